// File: rtl/rmt_pkg.sv
// Shared RMT pipeline types and constants used by the ingress admission logic
// and by the deparser-side credit sizing.
package rmt_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BODY = 1'b1
  } admit_state_e;

  localparam int RMT_MAX_INFLIGHT = 16;

endpackage

// File: rtl/admit_credit_cnt.sv
// Up/down credit counter that saturates at MAX and flags a sticky underflow
// when a decrement arrives at zero.
module admit_credit_cnt #(
  parameter int WIDTH = 8,
  parameter int MAX   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] cnt,
  output logic             underflow
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] LIM = WIDTH'(MAX);

  logic [WIDTH-1:0] cnt_r;
  logic [WIDTH-1:0] cnt_nxt_s;
  logic             uf_r;
  logic             uf_nxt_s;

  // Next count: a decrement at zero is absorbed (even with a paired increment)
  always_comb begin
    cnt_nxt_s = cnt_r;
    uf_nxt_s  = uf_r;
    if (dec && (cnt_r == '0)) begin
      uf_nxt_s  = 1'b1;
      cnt_nxt_s = cnt_r;
    end else if (inc && !dec) begin
      if (cnt_r < LIM) begin
        cnt_nxt_s = cnt_r + ONE;
      end else begin
        cnt_nxt_s = cnt_r;
      end
    end else if (dec && !inc) begin
      cnt_nxt_s = cnt_r - ONE;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Count and sticky underflow registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
      uf_r  <= 1'b0;
    end else begin
      cnt_r <= cnt_nxt_s;
      uf_r  <= uf_nxt_s;
    end
  end

  assign cnt       = cnt_r;
  assign underflow = uf_r;

endmodule

// File: rtl/pkt_admission_ctrl.sv
// Ingress admission controller: admits whole packets only when in-flight
// credits and packet-FIFO headroom allow. Optional stats: RMT_ADMIT_STATS_EN.
module pkt_admission_ctrl
  import rmt_pkg::*;
#(
  parameter int MAX_INFLIGHT = RMT_MAX_INFLIGHT,
  parameter int CNT_WIDTH    = 8,
  parameter int STAT_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  input  logic                  pkt_fifo_full,
  input  logic                  pkt_fifo_afull,
  input  logic                  pkt_retire,
  output logic                  sop_accept,
  output logic [CNT_WIDTH-1:0]  inflight_cnt,
  output logic                  retire_err,
  output logic [STAT_WIDTH-1:0] admit_cnt,
  output logic [STAT_WIDTH-1:0] stall_cnt
);

  admit_state_e         state_r;
  admit_state_e         state_nxt_s;
  logic                 tready_s;
  logic                 ready_s;
  logic                 accept_s;
  logic                 sop_s;
  logic                 credit_ok_s;
  logic [CNT_WIDTH-1:0] cnt_s;

  // Credit check uses the registered count; a same-cycle retire frees nothing yet
  assign credit_ok_s = (cnt_s < CNT_WIDTH'(MAX_INFLIGHT));

  // Next-state and pre-reset-gating ready
  always_comb begin
    state_nxt_s = state_r;
    tready_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        tready_s = credit_ok_s & ~pkt_fifo_afull & ~pkt_fifo_full;
        if (s_axis_tvalid && ready_s && !s_axis_tlast) begin
          state_nxt_s = ST_BODY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BODY: begin
        // A started packet is never stalled by credits or afull
        tready_s = ~pkt_fifo_full;
        if (s_axis_tvalid && ready_s && s_axis_tlast) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_BODY;
        end
      end
      default: begin
        tready_s    = 1'b0;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  assign ready_s  = tready_s & aresetn;
  assign accept_s = s_axis_tvalid & ready_s;
  assign sop_s    = accept_s & (state_r == ST_IDLE);

  // Packet-boundary state register
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  admit_credit_cnt #(
    .WIDTH (CNT_WIDTH),
    .MAX   (MAX_INFLIGHT)
  ) u_credit (
    .clk       (clk),
    .rst_n     (aresetn),
    .inc       (sop_s),
    .dec       (pkt_retire),
    .cnt       (cnt_s),
    .underflow (retire_err)
  );

  assign s_axis_tready = ready_s;
  assign sop_accept    = sop_s;
  assign inflight_cnt  = cnt_s;

`ifdef RMT_ADMIT_STATS_EN
  logic [STAT_WIDTH-1:0] admit_cnt_r;
  logic [STAT_WIDTH-1:0] stall_cnt_r;

  // Free-running wrap-around statistics
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      admit_cnt_r <= '0;
      stall_cnt_r <= '0;
    end else begin
      if (sop_s) begin
        admit_cnt_r <= admit_cnt_r + STAT_WIDTH'(1);
      end
      if (s_axis_tvalid && !ready_s) begin
        stall_cnt_r <= stall_cnt_r + STAT_WIDTH'(1);
      end
    end
  end

  assign admit_cnt = admit_cnt_r;
  assign stall_cnt = stall_cnt_r;
`else
  assign admit_cnt = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pkt_admission_ctrl.sv
// Scoreboard bench for pkt_admission_ctrl: directed scenarios plus random
// traffic checked against a packet-level reference model.
module tb_pkt_admission_ctrl;

  localparam int MAXI = 16;
  localparam int CW   = 8;
  localparam int SW   = 32;

  logic          clk = 1'b0;
  logic          aresetn;
  logic          s_axis_tvalid;
  logic          s_axis_tlast;
  logic          s_axis_tready;
  logic          pkt_fifo_full;
  logic          pkt_fifo_afull;
  logic          pkt_retire;
  logic          sop_accept;
  logic [CW-1:0] inflight_cnt;
  logic          retire_err;
  logic [SW-1:0] admit_cnt;
  logic [SW-1:0] stall_cnt;

  always #5 clk = ~clk;

  pkt_admission_ctrl #(
    .MAX_INFLIGHT (MAXI),
    .CNT_WIDTH    (CW),
    .STAT_WIDTH   (SW)
  ) dut (
    .clk            (clk),
    .aresetn        (aresetn),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tready  (s_axis_tready),
    .pkt_fifo_full  (pkt_fifo_full),
    .pkt_fifo_afull (pkt_fifo_afull),
    .pkt_retire     (pkt_retire),
    .sop_accept     (sop_accept),
    .inflight_cnt   (inflight_cnt),
    .retire_err     (retire_err),
    .admit_cnt      (admit_cnt),
    .stall_cnt      (stall_cnt)
  );

  typedef struct {
    logic          tready;
    logic          sop;
    logic [CW-1:0] cnt;
    logic          err;
    logic [SW-1:0] admits;
    logic [SW-1:0] stalls;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: packet-level view of the controller
  int          m_cnt;
  bit          m_in_pkt;
  bit          m_err;
  int unsigned m_admits;
  int unsigned m_stalls;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic bit model_ready(input bit f, input bit af);
    if (m_in_pkt) return !f;
    return (m_cnt < MAXI) && !af && !f;
  endfunction

  function automatic exp_t model_out(input bit rdy, input bit sop);
    exp_t e;
    e.tready = rdy;
    e.sop    = sop;
    e.cnt    = CW'(m_cnt);
    e.err    = m_err;
`ifdef RMT_ADMIT_STATS_EN
    e.admits = SW'(m_admits);
    e.stalls = SW'(m_stalls);
`else
    e.admits = '0;
    e.stalls = '0;
`endif
    return e;
  endfunction

  // One clock cycle of stimulus; expectation queued before the edge
  task automatic drive(input bit v, input bit l, input bit f, input bit af, input bit r);
    bit rdy;
    bit acc;
    bit sop;
    s_axis_tvalid  = v;
    s_axis_tlast   = l;
    pkt_fifo_full  = f;
    pkt_fifo_afull = af;
    pkt_retire     = r;
    rdy = model_ready(f, af);
    acc = v && rdy;
    sop = acc && !m_in_pkt;
    exp_q.push_back(model_out(rdy, sop));
    @(posedge clk);
    if (acc) m_in_pkt = !l;
    if (r && m_cnt == 0) m_err = 1'b1;
    else m_cnt = m_cnt + (sop ? 1 : 0) - (r ? 1 : 0);
    if (sop) m_admits++;
    if (v && !rdy) m_stalls++;
    #1;
  endtask

  task automatic do_reset(input int cycles);
    aresetn        = 1'b0;
    s_axis_tvalid  = 1'b0;
    s_axis_tlast   = 1'b0;
    pkt_fifo_full  = 1'b0;
    pkt_fifo_afull = 1'b0;
    pkt_retire     = 1'b0;
    m_cnt    = 0;
    m_in_pkt = 1'b0;
    m_err    = 1'b0;
    m_admits = 0;
    m_stalls = 0;
    for (int i = 0; i < cycles; i++) begin
      exp_q.push_back(model_out(1'b0, 1'b0));
      @(posedge clk);
      #1;
    end
    aresetn = 1'b1;
  endtask

  // Monitor: one scoreboard entry per cycle, sampled on the falling edge
  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("tready", 32'(s_axis_tready), 32'(e.tready));
      chk("sop_accept", 32'(sop_accept), 32'(e.sop));
      chk("inflight_cnt", 32'(inflight_cnt), 32'(e.cnt));
      chk("retire_err", 32'(retire_err), 32'(e.err));
      chk("admit_cnt", admit_cnt, e.admits);
      chk("stall_cnt", stall_cnt, e.stalls);
    end
  end

  initial begin
    aresetn        = 1'b0;
    s_axis_tvalid  = 1'b0;
    s_axis_tlast   = 1'b0;
    pkt_fifo_full  = 1'b0;
    pkt_fifo_afull = 1'b0;
    pkt_retire     = 1'b0;
    @(posedge clk);
    #1;
    do_reset(2);

    // single-beat then 4-beat packet
    drive(1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    chk("two_pkts_cnt", 32'(inflight_cnt), 32'd2);

    // credit exhaustion and release
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    chk("credit_full_cnt", 32'(inflight_cnt), 32'd16);
    chk("credit_full_ready", 32'(s_axis_tready), 32'd0);
    drive(1, 1, 0, 0, 1);
    drive(1, 1, 0, 0, 0);
    chk("after_retire_cnt", 32'(inflight_cnt), 32'd16);

    // body beats are not credit-gated
    drive(0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 0);
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    chk("body_done_cnt", 32'(inflight_cnt), 32'd16);

    // simultaneous admit and retire at count 5
    for (int i = 0; i < 11; i++) drive(0, 0, 0, 0, 1);
    drive(1, 1, 0, 0, 1);
    chk("sim_admit_retire", 32'(inflight_cnt), 32'd5);

    // underflow is sticky
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0);
    chk("underflow_cnt", 32'(inflight_cnt), 32'd0);
    chk("underflow_err", 32'(retire_err), 32'd1);

    // fifo full mid-packet, then reset mid-packet
    do_reset(2);
    chk("reset_err", 32'(retire_err), 32'd0);
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
`ifdef RMT_ADMIT_STATS_EN
    chk("stall_cnt_3", stall_cnt, 32'd3);
    chk("admit_cnt_1", admit_cnt, 32'd1);
`endif
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    do_reset(1);
    chk("midpkt_reset_cnt", 32'(inflight_cnt), 32'd0);
    drive(1, 1, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit v, l, f, af, r;
      v  = ($urandom_range(0, 9) < 7);
      l  = ($urandom_range(0, 3) == 0);
      f  = ($urandom_range(0, 9) == 0);
      af = ($urandom_range(0, 6) == 0);
      r  = (m_cnt > 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 49) == 0);
      drive(v, l, f, af, r);
      if (i == 1500) do_reset(2);
    end

    @(negedge clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
